idex_pipe_reg: RTL

//  Parametrised ID/EX pipeline register, successor to the plain clocked ID/EX latch.

---
 rtl/idex_pkg.sv | 24 ++
 rtl/idex_slot.sv | 20 ++
 rtl/idex_pipe_reg.sv | 123 ++++++++++++
 3 files changed

// File: rtl/idex_pkg.sv
// Shared constants for the ID/EX pipeline register: control-bundle layout and FSM states.
package idex_pkg;

  localparam int unsigned CTRL_W = 13;

  localparam int unsigned REGWRT    = 0;
  localparam int unsigned MEMTOREG  = 1;
  localparam int unsigned PCTOREG   = 2;
  localparam int unsigned BRNEG     = 3;
  localparam int unsigned BRZERO    = 4;
  localparam int unsigned JUMP      = 5;
  localparam int unsigned JUMPMEM   = 6;
  localparam int unsigned MEMREAD   = 7;
  localparam int unsigned MEMWRT    = 8;
  localparam int unsigned ALUOP_LSB = 9;
  localparam int unsigned ALUOP_MSB = 12;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_e;

endpackage

// File: rtl/idex_slot.sv
// One storage slot of the ID/EX register: width-W register with load enable and async clear.
module idex_slot #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/idex_pipe_reg.sv
// ID/EX pipeline register with valid/ready handshake, one-entry skid buffer, flush and
// bubble masking of the control bundle.
module idex_pipe_reg
  import idex_pkg::*;
#(
  parameter int unsigned CTRL_W = 13,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_W  = 6,
  parameter int unsigned PC_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_rs,
  input  logic [DATA_W-1:0] in_rt,
  input  logic [REG_W-1:0]  in_rd,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt,
  output logic [REG_W-1:0]  out_rd,
  output logic [PC_W-1:0]   out_pc,
  output logic [1:0]        occupancy
);

  localparam int unsigned W = CTRL_W + 2 * DATA_W + REG_W + PC_W;

  state_e            state_q, state_d;
  logic              accept, consume;
  logic              main_load, skid_load;
  logic [W-1:0]      in_word, main_d, main_q, skid_q;
  logic [CTRL_W-1:0] main_ctrl;

  assign in_word = {in_ctrl, in_rs, in_rt, in_rd, in_pc};
  assign accept  = in_valid & in_ready;
  assign consume = out_valid & out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) state_d = HALF;
        HALF: begin
          if (accept && !consume) state_d = FULL;
          else if (!accept && consume) state_d = EMPTY;
        end
        FULL:  if (consume) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Flush suppresses every slot write, so a discarded input never lands in storage.
  always_comb begin
    main_load = 1'b0;
    skid_load = 1'b0;
    main_d    = in_word;
    if (!flush) begin
      case (state_q)
        EMPTY: main_load = accept;
        HALF: begin
          main_load = accept & consume;
          skid_load = accept & ~consume;
        end
        FULL: begin
          main_load = consume;
          main_d    = skid_q;
        end
        default: ;
      endcase
    end
  end

  idex_slot #(
    .W(W)
  ) u_main (
    .clk (clk),
    .rst (rst),
    .load(main_load),
    .d   (main_d),
    .q   (main_q)
  );

  idex_slot #(
    .W(W)
  ) u_skid (
    .clk (clk),
    .rst (rst),
    .load(skid_load),
    .d   (in_word),
    .q   (skid_q)
  );

  assign {main_ctrl, out_rs, out_rt, out_rd, out_pc} = main_q;

  // in_ready depends only on registered state (and rst), never on out_ready.
  always_comb begin
    out_valid = (state_q != EMPTY);
    in_ready  = ~rst & (state_q != FULL);
    out_ctrl  = out_valid ? main_ctrl : '0;
    case (state_q)
      HALF:    occupancy = 2'd1;
      FULL:    occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

endmodule
